// File: rtl/serial_word_adder_pkg.sv
// Shared definitions for the serial word adder: slice width, FSM state
// encoding and the index width helper.
package serial_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, floored at 1 so a byte index always has at least one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/serial_word_adder_if.sv
// Handshake bundle for serial_word_adder: operand input port (valid/ready)
// and result output port (valid/ready). The ovf signal exists only when
// SIGNED_OVF_EN is defined.
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds its data stable
// while valid is high and ready is low.
import serial_add_pkg::*;

interface serial_word_adder_if #(
    parameter int WORDS = 4
);
    localparam int W = WORDS * BYTE_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SIGNED_OVF_EN
    logic         ovf;
`endif

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef SIGNED_OVF_EN
        , input ovf
`endif
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef SIGNED_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_word_adder_ripple_carry.sv
// 8-bit ripple-carry adder slice: S = A + B + C, Cout is the carry out of
// bit 7. Purely combinational.
module ripple_carry (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       C,
    output logic [7:0] S,
    output logic       Cout
);

    // Bit-by-bit full adders chained through a running carry.
    always_comb begin
        logic c;
        S = '0;
        c = C;
        for (int i = 0; i < 8; i++) begin
            S[i] = A[i] ^ B[i] ^ c;
            c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        Cout = c;
    end

endmodule

// File: rtl/serial_word_adder.sv
// serial_word_adder: adds two WORDS-byte operands plus carry-in one byte per
// cycle through a single ripple_carry slice, then holds {cout, sum} on a
// valid/ready output port until it is taken.
// Optional feature: define SIGNED_OVF_EN to add the registered signed
// overflow flag ovf.
import serial_add_pkg::*;

module serial_word_adder #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_word_adder_if.slave  bus,
    output state_t              dbg_state
);

    localparam int W  = WORDS * BYTE_W;
    localparam int IW = clog2(WORDS);

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            out_valid_q;
`ifdef SIGNED_OVF_EN
    logic            ovf_q;
`endif

    logic [BYTE_W-1:0] slice_a;
    logic [BYTE_W-1:0] slice_b;
    logic [BYTE_W-1:0] slice_s;
    logic              slice_co;
    logic              last_byte;

    assign slice_a   = a_q[int'(idx) * BYTE_W +: BYTE_W];
    assign slice_b   = b_q[int'(idx) * BYTE_W +: BYTE_W];
    assign last_byte = (idx == IW'(WORDS - 1));

    ripple_carry u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .C    (carry),
        .S    (slice_s),
        .Cout (slice_co)
    );

    // Sequencer: capture operands in IDLE, one byte per cycle in RUN, hold
    // the result in DONE until the output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        carry <= bus.cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx) * BYTE_W +: BYTE_W] <= slice_s;
                    carry <= slice_co;
                    idx   <= idx + 1'b1;
                    if (last_byte) begin
                        idx         <= '0;
                        cout_q      <= slice_co;
                        out_valid_q <= 1'b1;
`ifdef SIGNED_OVF_EN
                        // Top byte's slice sum carries the result MSB.
                        ovf_q <= (a_q[W-1] == b_q[W-1]) &&
                                 (slice_s[BYTE_W-1] != a_q[W-1]);
`endif
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SIGNED_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
    assign dbg_state     = state;

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed testbench for serial_word_adder with WORDS=4.
import serial_add_pkg::*;

module tb_serial_word_adder;

    localparam int WORDS = 4;
    localparam int W     = WORDS * BYTE_W;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     total;
    int     bad;
    logic [W:0] exp_q[$];

    serial_word_adder_if #(.WORDS(WORDS)) bus ();

    serial_word_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operand pair and return just after the accepting edge.
    task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic [W:0] exp);
        int n;
        exp_q.push_back(exp);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid, check latency and {cout, sum} against the queue.
    task automatic wait_result(input string tag, input logic exp_ovf);
        int n;
        logic [W:0] exp;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 20);
        check({tag, "_latency"}, 64'(n), 64'(WORDS));
        exp = exp_q.pop_front();
        check({tag, "_sum"},  64'(bus.sum),  64'(exp[W-1:0]));
        check({tag, "_cout"}, 64'(bus.cout), 64'(exp[W]));
`ifdef SIGNED_OVF_EN
        check({tag, "_ovf"},  64'(bus.ovf),  64'(exp_ovf));
`else
        if (exp_ovf) $display("note: %s ovf not built", tag);
`endif
    endtask

    // Take the result and confirm the block is ready again after that edge.
    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"},    64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_sum",       64'(bus.sum),       64'd0);
        check("rst_cout",      64'(bus.cout),      64'd0);
        check("rst_state",     64'(dbg_state),     64'(IDLE));

        // 1. Simple add
        accept(32'h0000_0001, 32'h0000_0001, 1'b0, {1'b0, 32'h0000_0002});
        check("simple_busy", 64'(bus.busy), 64'd1);
        wait_result("simple", 1'b0);
        take("simple");

        // 2. Byte carry chain
        accept(32'h0000_00FF, 32'h0000_0001, 1'b0, {1'b0, 32'h0000_0100});
        wait_result("chain", 1'b0);
        take("chain");

        // 3. Full wrap
        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0000_0000});
        wait_result("wrap1", 1'b0);
        take("wrap1");
        accept(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, {1'b1, 32'h0000_0000});
        wait_result("wrap2", 1'b0);
        take("wrap2");

`ifdef SIGNED_OVF_EN
        // 4. Signed overflow
        accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h8000_0000});
        wait_result("ovf", 1'b1);
        take("ovf");
`endif

        // 5. Backpressure with new operands offered during DONE
        accept(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 32'h2345_6789});
        wait_result("bp", 1'b0);
        bus.in_valid = 1'b1;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0BAD_F00D;
        bus.cin      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_sum",       64'(bus.sum),       64'h2345_6789);
            check("bp_cout",      64'(bus.cout),      64'd0);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_state",     64'(dbg_state),     64'(DONE));
        end
        bus.in_valid = 1'b0;
        take("bp");
        @(posedge clk);
        #1;
        check("bp_not_captured", 64'(bus.busy), 64'd0);

        // 6. Reset two cycles after accept
        accept(32'h0102_0304, 32'h0506_0708, 1'b0, {1'b0, 32'h0000_0000});
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_sum",       64'(bus.sum),       64'd0);
        check("mid_rst_cout",      64'(bus.cout),      64'd0);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy",      64'(bus.busy),      64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef SIGNED_OVF_EN
        check("mid_rst_ovf",       64'(bus.ovf),       64'd0);
`endif
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) pulses++;
            end
            check("mid_rst_no_pulse", 64'(pulses), 64'd0);
        end
        accept(32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b1, {1'b1, 32'hE1E1_E1E1});
        wait_result("after_rst", 1'b0);
        take("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_adder.md
# serial_word_adder

Multi-byte sequential adder front-end that feeds the team's 8-bit ripple-carry adder slice one byte per cycle and assembles its sum and carry outputs into a full-width result. It accepts a WORDS×8-bit operand pair plus carry-in over a valid/ready handshake. It chains each slice's carry-out into the next slice's carry-in, and presents the registered result on a valid/ready output port. It sits directly upstream of the `ripple_carry` slice, which it instantiates, and consumes what that slice produces.

## Interface
- `WORDS`, default 4: number of byte slices. Legal range is 2..16.
- `BYTE_W`, default 8: slice width. Fixed at 8 to match `ripple_carry`.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `in_valid`  in  1: the operand pair is offered.
- `in_ready`  out  1: the block can accept operands. It is high only in IDLE.
- `a`  in  WORDS*8: operand A. Byte 0 is bits [7:0].
- `b`  in  WORDS*8: operand B.
- `cin`  in  1: carry into byte 0.
- `out_valid`  out  1: the result is held on `sum`/`cout`.
- `out_ready`  in  1: downstream accepts the result.
- `sum`  out  WORDS*8: the registered sum.
- `cout`  out  1: carry out of the top byte.
- `busy`  out  1: high in RUN or DONE.
- `ovf`  out  1: signed overflow. Present only when `SIGNED_OVF_EN` is defined.

## Operation
- FSM states are IDLE, RUN and DONE.
- Reset, applied in any state, forces:
  - state = IDLE, index = 0, carry register = 0;
  - `sum` = 0, `cout` = 0, `out_valid` = 0, `busy` = 0, `ovf` = 0.
  - `in_ready` reads 1 on the cycle after the reset edge.
- IDLE:
  - When `in_valid & in_ready` is true, capture `a`, `b` and `cin` into operand registers.
  - Set the carry register to `cin` and the index to 0, then go to RUN.
  - Inputs are ignored when `in_valid` is low.
- RUN, each cycle:
  - The slice computes byte[index] of A + byte[index] of B + the carry register.
  - At the edge, byte[index] of `sum` takes the slice sum, the carry register takes the slice carry-out, and the index increments.
  - When index == WORDS-1, write the final byte, copy the slice carry-out to `cout`, and go to DONE.
- DONE:
  - `out_valid` = 1, and `sum`/`cout`/`ovf` are held stable.
  - When `out_ready` is high, go to IDLE at that edge and drop `out_valid`.
- `in_ready` is 0 in RUN and DONE. `in_valid` in those states is ignored and the operands are not captured.
- Arithmetic: the result is {`cout`, `sum`} = `a` + `b` + `cin`, computed modulo 2^(WORDS*8+1). There is no saturation.
- Bytes of `sum` not yet written in RUN keep the previous result's values. Downstream uses `sum` only while `out_valid` is high.
- Reset asserted mid-RUN or mid-DONE abandons the operation. No `out_valid` pulse is produced for it.

## Timing
- Take the accepting edge as k.
- Byte i is written at edge k+1+i.
- `out_valid` rises after edge k+WORDS. With WORDS=4 that is 4 cycles after acceptance.
- Taking the output handshake edge as m, `in_ready` returns high after edge m.
- The minimum initiation interval is WORDS+2 cycles. Input and output handshakes never overlap.
- All outputs are registered, except `in_ready` and `busy`, which are decoded directly from the state register.

## Configuration
- `SIGNED_OVF_EN` defined:
  - Adds the `ovf` output.
  - `ovf` is registered at the same edge as `cout`.
  - `ovf` = (a MSB == b MSB) & (sum MSB != a MSB), i.e. two's-complement overflow of the full-width add.
- `SIGNED_OVF_EN` undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `serial_add_pkg` holds:
  - the `BYTE_W` constant;
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the index width function clog2(WORDS).
- There is exactly one sub-module, an instance of the existing 8-bit `ripple_carry` slice (A, B, C → S, Cout).
  - Its A and B are driven by byte-selecting the operand registers with the index.
  - Its C is driven by the carry register.
- No other hierarchy.

## Test plan
All scenarios use WORDS=4.
1. **Simple add.** a=0x00000001, b=0x00000001, cin=0 → sum=0x00000002, cout=0. `out_valid` rises exactly 4 cycles after the accept edge.
2. **Byte carry chain.** a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0.
3. **Full wrap.**
   - a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, `ovf`=0.
   - a=0xAAAAAAAA, b=0x55555555, cin=1 → sum=0x00000000, cout=1.
4. **Signed overflow (`SIGNED_OVF_EN` defined).** a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, `ovf`=1.
5. **Backpressure.** Hold `out_ready` low for 5 cycles in DONE, with `in_valid` high carrying new operands.
   - `sum`/`cout` stay stable, `in_ready` stays 0, and the new operands are not captured.
   - After `out_ready` rises, `in_ready` returns 1 one cycle later.
6. **Reset mid-RUN.** Assert `rst` for 1 cycle two cycles after accept.
   - Every output returns to its reset value, and `out_valid` never pulses.
   - A subsequent add of a=0xF0F0F0F0, b=0xF0F0F0F0, cin=1 gives sum=0xE1E1E1E1, cout=1.
